// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter: widths, memory size and FSM encodings.
package dmem_port_arbiter_pkg;

    localparam int DMEM_D_WIDTH   = 32;
    localparam int DMEM_ADDR_BITS = 8;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_HOLD = 1'b1;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Serialises a 2-wide load/store bundle onto the single-port data memory in program order
// (lane0 before lane1), returning registered load data per lane.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int D_WIDTH   = DMEM_D_WIDTH,
    parameter int ADDR_BITS = DMEM_ADDR_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid0,
    input  logic               i_we0,
    input  logic [D_WIDTH-1:0] i_addr0,
    input  logic [D_WIDTH-1:0] i_wdata0,
    input  logic               i_valid1,
    input  logic               i_we1,
    input  logic [D_WIDTH-1:0] i_addr1,
    input  logic [D_WIDTH-1:0] i_wdata1,
    // Handshake: a bundle is taken in any cycle where o_busy is 0 and at least one i_validN is
    // set; while o_busy is 1 the bundle inputs are ignored and upstream must stall.
    output logic               o_busy,
    output logic [D_WIDTH-1:0] o_mem_addr,
    output logic [D_WIDTH-1:0] o_mem_wdata,
    output logic               o_mem_we,
    input  logic [D_WIDTH-1:0] i_mem_rd,
    output logic               o_rvalid0,
    output logic [D_WIDTH-1:0] o_rdata0,
    output logic               o_rvalid1,
    output logic [D_WIDTH-1:0] o_rdata1,
    output logic               o_addr_err,
    output logic               dbg_state
);

    // Highest start address whose 4-byte access still fits inside the memory.
    localparam logic [D_WIDTH-1:0] ADDR_MAX = D_WIDTH'((64'd1 << ADDR_BITS) - 64'd4);

    logic [0:0]         state;
    logic [0:0]         state_nxt;
    logic               hold_valid;
    logic               hold_we;
    logic [D_WIDTH-1:0] hold_addr;
    logic [D_WIDTH-1:0] hold_wdata;
    logic [D_WIDTH-1:0] last_addr;
    logic [D_WIDTH-1:0] last_wdata;

    logic               serve_valid;
    logic               serve_we;
    logic               serve_lane;
    logic [D_WIDTH-1:0] serve_addr;
    logic [D_WIDTH-1:0] serve_wdata;
    logic               serve_ok;
    logic               accept_dual;

    always_comb begin
        serve_valid = 1'b0;
        serve_we    = 1'b0;
        serve_lane  = 1'b0;
        serve_addr  = last_addr;
        serve_wdata = last_wdata;
        accept_dual = 1'b0;
        state_nxt   = state;
        if (state == ARB_IDLE) begin
            if (i_valid0) begin
                serve_valid = 1'b1;
                serve_we    = i_we0;
                serve_lane  = 1'b0;
                serve_addr  = i_addr0;
                serve_wdata = i_wdata0;
                if (i_valid1) begin
                    accept_dual = 1'b1;
                    state_nxt   = ARB_HOLD;
                end
            end else if (i_valid1) begin
                serve_valid = 1'b1;
                serve_we    = i_we1;
                serve_lane  = 1'b1;
                serve_addr  = i_addr1;
                serve_wdata = i_wdata1;
            end
        end else begin
            serve_valid = hold_valid;
            serve_we    = hold_we;
            serve_lane  = 1'b1;
            serve_addr  = hold_addr;
            serve_wdata = hold_wdata;
            state_nxt   = ARB_IDLE;
        end
    end

    assign serve_ok    = (serve_addr <= ADDR_MAX);
    assign o_mem_addr  = serve_addr;
    assign o_mem_wdata = serve_wdata;
    assign o_mem_we    = serve_valid & serve_we & serve_ok;
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ARB_IDLE;
            o_busy <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_busy <= (state_nxt == ARB_HOLD);
        end
    end

    // Hold buffer: lane1 of a dual bundle waits here for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else if (accept_dual) begin
            hold_valid <= 1'b1;
            hold_we    <= i_we1;
            hold_addr  <= i_addr1;
            hold_wdata <= i_wdata1;
        end else if (state == ARB_HOLD) begin
            hold_valid <= 1'b0;
        end
    end

    // Memory address/data keep their last served value on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr  <= '0;
            last_wdata <= '0;
        end else if (serve_valid) begin
            last_addr  <= serve_addr;
            last_wdata <= serve_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rvalid0  <= 1'b0;
            o_rvalid1  <= 1'b0;
            o_rdata0   <= '0;
            o_rdata1   <= '0;
            o_addr_err <= 1'b0;
        end else begin
            o_rvalid0  <= serve_valid & ~serve_we & ~serve_lane;
            o_rvalid1  <= serve_valid & ~serve_we & serve_lane;
            o_addr_err <= serve_valid & ~serve_ok;
            if (serve_valid && !serve_we && !serve_lane) begin
                o_rdata0 <= serve_ok ? i_mem_rd : '0;
            end
            if (serve_valid && !serve_we && serve_lane) begin
                o_rdata1 <= serve_ok ? i_mem_rd : '0;
            end
        end
    end

endmodule
